axis_position_controller: RTL

- Closed-loop proportional position controller for one gimbal axis (pitch or yaw).
- Samples the quadrature decoder count at a fixed rate and compares it with a software setpoint.
- Produces the 32-bit control word consumed by the Steering PWM block: [31]=software_reset, [30]=dir, [COUNT_SIZE-1:0]=duty.
- Sits between the Avalon register file (setpoint/gain/enable registers) and one Steering instance; one instance per axis.

---
 rtl/axis_position_controller_if.sv | 44 ++++
 rtl/axis_position_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axis_position_controller_if.sv
// axis_position_controller_if
//   Bundles the register-file side and Steering side signals of one gimbal
//   axis position controller.
//   master : drives loop enable, setpoint, position, gain, shift and duty
//            ceiling; observes the control word and status flags.
//   slave  : the controller itself.
//   Signals:
//     enable       loop enable
//     setpoint     signed target count
//     position     signed quadrature decoder count
//     kp           unsigned proportional gain
//     kp_shift     right shift applied to the gain product
//     max_duty     duty ceiling
//     control_out  Steering control word {sw_reset, dir, zero fill, duty}
//     update       one-cycle pulse when control_out is reloaded
//     at_target    last sample was inside the deadband
//     saturated    last sample was clamped to max_duty
//     busy         controller is computing a sample
interface axis_position_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COUNT_SIZE = 11
);
  logic                         enable;
  logic signed [DATA_WIDTH-1:0] setpoint;
  logic signed [DATA_WIDTH-1:0] position;
  logic [7:0]                   kp;
  logic [3:0]                   kp_shift;
  logic [COUNT_SIZE-1:0]        max_duty;
  logic [DATA_WIDTH-1:0]        control_out;
  logic                         update;
  logic                         at_target;
  logic                         saturated;
  logic                         busy;

  modport master (
    output enable, setpoint, position, kp, kp_shift, max_duty,
    input  control_out, update, at_target, saturated, busy
  );

  modport slave (
    input  enable, setpoint, position, kp, kp_shift, max_duty,
    output control_out, update, at_target, saturated, busy
  );
endinterface

// File: rtl/axis_position_controller.sv
// axis_position_controller
//   Proportional position loop for one gimbal axis. Every PERIOD_CYCLES
//   clocks the setpoint/position error is sampled, scaled by kp >> kp_shift,
//   clamped to max_duty and packed into the Steering control word. A
//   direction reversal is preceded by one zero-duty brake sample.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    axis_position_controller_if.slave (register file / Steering side)
module axis_position_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_SIZE    = 11,
  parameter int PERIOD_CYCLES = 50000,
  parameter int DEADBAND      = 2
) (
  input logic                         clk,
  input logic                         reset,
  axis_position_controller_if.slave   bus
);

  localparam int ERR_W  = DATA_WIDTH + 1;
  localparam int PROD_W = ERR_W + 8;
  localparam int CNT_W  = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CTRL_RST = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, SCALE, APPLY} state_t;

  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
    return e[ERR_W-1] ? ERR_W'(-e) : ERR_W'(e);
  endfunction

  function automatic logic [COUNT_SIZE-1:0] sat_duty(input logic [PROD_W-1:0] p,
                                                     input logic [COUNT_SIZE-1:0] m);
    return (p > PROD_W'(m)) ? m : p[COUNT_SIZE-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ctrl_word(input logic d,
                                                      input logic [COUNT_SIZE-1:0] duty);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-2]   = d;
    w[COUNT_SIZE-1:0] = duty;
    return w;
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;

  logic signed [ERR_W-1:0] diff;
  logic [PROD_W-1:0]       prod_full;

  logic signed [ERR_W-1:0] err_p0;
  logic                    dir_p0;
  logic [7:0]              kp_p0;
  logic [3:0]              shift_p0;
  logic [COUNT_SIZE-1:0]   max_p0;

  logic [ERR_W-1:0]        abs_p1;
  logic                    dir_p1;
  logic [PROD_W-1:0]       prod_p1;
  logic [COUNT_SIZE-1:0]   max_p1;

  logic [COUNT_SIZE-1:0]   duty_a;
  logic                    dir_a, at_a, sat_a;

  logic [DATA_WIDTH-1:0]   control_q;
  logic                    update_q, at_target_q, saturated_q;
  logic                    prev_dir;
  logic [COUNT_SIZE-1:0]   prev_duty;

  assign diff = {bus.setpoint[DATA_WIDTH-1], bus.setpoint}
              - {bus.position[DATA_WIDTH-1], bus.position};
  assign prod_full = PROD_W'(abs_err(err_p0)) * PROD_W'(kp_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the APPLY-stage duty decision
  always_comb begin
    state_nxt = state;
    duty_a    = '0;
    dir_a     = dir_p1;
    at_a      = 1'b0;
    sat_a     = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT;
        WAIT:    if (cnt == CNT_LAST) state_nxt = SAMPLE;
        SAMPLE:  state_nxt = SCALE;
        SCALE:   state_nxt = APPLY;
        APPLY:   state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
    end
    if (abs_p1 <= ERR_W'(DEADBAND)) begin
      at_a = 1'b1;
    end else if ((dir_p1 != prev_dir) && (prev_duty != '0)) begin
      // Brake sample: zero duty, hold the old direction one more period
      dir_a = prev_dir;
    end else begin
      duty_a = sat_duty(prod_p1, max_p1);
      sat_a  = prod_p1 > PROD_W'(max_p1);
    end
  end

  // Period counter keeps running through the compute states so the
  // sample rate stays exactly one per PERIOD_CYCLES
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (!bus.enable || state == IDLE)  cnt <= '0;
    else if (cnt == CNT_LAST)               cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end

  // Stage p0 (SAMPLE): capture error, direction and gain settings
  // Stage p1 (SCALE): magnitude and scaled product
  always_ff @(posedge clk) begin
    if (state == SAMPLE) begin
      err_p0   <= diff;
      dir_p0   <= !diff[ERR_W-1] && (diff != '0);
      kp_p0    <= bus.kp;
      shift_p0 <= bus.kp_shift;
      max_p0   <= bus.max_duty;
    end
    if (state == SCALE) begin
      abs_p1  <= abs_err(err_p0);
      dir_p1  <= dir_p0;
      prod_p1 <= prod_full >> shift_p0;
      max_p1  <= max_p0;
    end
  end

  // Stage p2 (APPLY): load the control word and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_q   <= CTRL_RST;
      update_q    <= 1'b0;
      at_target_q <= 1'b0;
      saturated_q <= 1'b0;
      prev_dir    <= 1'b0;
      prev_duty   <= '0;
    end else if (!bus.enable) begin
      control_q   <= CTRL_RST;
      update_q    <= 1'b0;
      at_target_q <= 1'b0;
      saturated_q <= 1'b0;
      prev_dir    <= 1'b0;
      prev_duty   <= '0;
    end else begin
      update_q <= 1'b0;
      if (state == APPLY) begin
        control_q   <= ctrl_word(dir_a, duty_a);
        update_q    <= 1'b1;
        at_target_q <= at_a;
        saturated_q <= sat_a;
        prev_dir    <= dir_a;
        prev_duty   <= duty_a;
      end else if (state == IDLE) begin
        control_q <= CTRL_RST;
      end
    end
  end

  assign bus.control_out = control_q;
  assign bus.update      = update_q;
  assign bus.at_target   = at_target_q;
  assign bus.saturated   = saturated_q;
  assign bus.busy        = (state == SAMPLE) || (state == SCALE) || (state == APPLY);

endmodule
